mem_arbiter: RTL and testbench

//   Shares the single 16-bit memory port between the CPU and a DMA/boot-loader requester.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_sat_counter.sv | 51 +++++
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the CPU/DMA memory-port arbiter: FSM state
//   encodings, grant identifiers and a counter-width helper.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Arbiter FSM states: idle/arbitrating, CPU access, DMA access.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } arb_state_e;

  // Identity of the most recently granted master.
  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_e;

  // Bits needed to hold 0..limit (at least one bit, so limit 0 still works).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear. Counts 0..LIMIT and holds
//   at LIMIT; clear takes priority over increment.
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high
//   inc       in   increment request
//   clr       in   clear to zero (wins over inc)
//   at_limit  out  count currently equals LIMIT
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT_V)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit = (count_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one 16-bit memory port between a CPU and a DMA/boot-loader
//   requester. Fixed CPU priority, with a starvation guard that forces a DMA
//   grant after STARVE_LIMIT consecutive CPU wins over a pending DMA, and
//   locked DMA bursts bounded to MAX_BURST accesses. Each access lasts
//   WAIT_STATES+1 cycles; the requester then gets a one-cycle ready pulse
//   with registered read data.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request (held until cpu_ready)
//   cpu_rdata, cpu_ready       CPU read data (valid with ready), done pulse
//   dma_req/lock/we/addr/wdata DMA request; lock asks for burst continuation
//   dma_rdata, dma_ready       DMA read data, done pulse
//   mem_addr/wdata/we          memory port, all zero while idle
//   mem_rdata                  memory read data, sampled in last access cycle
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  arb_state_e  state_d, state_q;
  grant_e      last_gnt_d, last_gnt_q;
  logic        cpu_ready_d, cpu_ready_q;
  logic        dma_ready_d, dma_ready_q;
  logic [15:0] cpu_rdata_d, cpu_rdata_q;
  logic [15:0] dma_rdata_d, dma_rdata_q;

  logic in_acc;
  logic wait_done;
  logic starve_hit;
  logic burst_full;
  logic grant_cpu;
  logic grant_dma;

  assign in_acc = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // Arbitration: only evaluated in IDLE (including the ready cycle, which is
  // what makes back-to-back accesses possible).
  // -------------------------------------------------------------------------
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state_q == ST_IDLE) begin
      if (dma_req && dma_lock && (last_gnt_q == GNT_DMA) && !burst_full) begin
        grant_dma = 1'b1;            // locked burst continuation
      end else if (dma_req && starve_hit) begin
        grant_dma = 1'b1;            // starvation guard
      end else if (cpu_req) begin
        grant_cpu = 1'b1;            // fixed CPU priority
      end else if (dma_req) begin
        grant_dma = 1'b1;
      end
    end
  end

  // Wait counter runs 0..WAIT_STATES during an access; reaching the limit
  // marks the final access cycle.
  sat_counter #(
    .WIDTH (cnt_width(WAIT_STATES)),
    .LIMIT (WAIT_STATES)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (in_acc),
    .clr      (!in_acc || wait_done),
    .at_limit (wait_done)
  );

  // Consecutive CPU wins while DMA was waiting.
  sat_counter #(
    .WIDTH (cnt_width(STARVE_LIMIT)),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant_cpu && dma_req),
    .clr      (grant_dma),
    .at_limit (starve_hit)
  );

  // Length of the current locked DMA burst.
  sat_counter #(
    .WIDTH (cnt_width(MAX_BURST)),
    .LIMIT (MAX_BURST)
  ) u_burst_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant_dma && dma_lock),
    .clr      (grant_cpu || (grant_dma && !dma_lock)),
    .at_limit (burst_full)
  );

  // -------------------------------------------------------------------------
  // FSM next-state, ready pulses and read-data capture.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_cpu) begin
          state_d    = ST_CPU;
          last_gnt_d = GNT_CPU;
        end else if (grant_dma) begin
          state_d    = ST_DMA;
          last_gnt_d = GNT_DMA;
        end
      end
      ST_CPU: begin
        if (wait_done) begin
          state_d     = ST_IDLE;
          cpu_ready_d = 1'b1;
          if (!cpu_we) cpu_rdata_d = mem_rdata;
        end
      end
      ST_DMA: begin
        if (wait_done) begin
          state_d     = ST_IDLE;
          dma_ready_d = 1'b1;
          if (!dma_we) dma_rdata_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= GNT_CPU;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory port mux: driven live from the granted master, zero when idle.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      ST_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      ST_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
      end
      default: ;
    endcase
  end

  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Three arbiters share one stimulus set: index 0 has WAIT_STATES=1,
//   index 1 has WAIT_STATES=0, index 2 has WAIT_STATES=3. Each scenario task
//   checks the instance whose wait-state setting it targets.
//   Memory model: address 0x1234 reads 0xBEEF, any other address reads
//   addr ^ 0xC0DE.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        dma_req, dma_lock, dma_we;
  logic [15:0] dma_addr, dma_wdata;

  logic [15:0] cpu_rdata [3];
  logic [15:0] dma_rdata [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic        cpu_ready [3];
  logic        dma_ready [3];
  logic        mem_we    [3];

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'hC0DE);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    mem_arbiter #(
      .WAIT_STATES  (W),
      .STARVE_LIMIT (4),
      .MAX_BURST    (8)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_ready (cpu_ready[g]),
      .dma_req   (dma_req),
      .dma_lock  (dma_lock),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata[g]),
      .dma_ready (dma_ready[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata[g])
    );
    assign mem_rdata[g] = mem_model(mem_addr[g]);
  end

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dma_req   = 1'b0;
    dma_lock  = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int g = 0; g < 3; g++) begin
      total++;
      if (cpu_ready[g] !== 1'b0 || dma_ready[g] !== 1'b0 || mem_we[g] !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctrl[%0d]: cpu_ready=%b dma_ready=%b mem_we=%b want 0 0 0",
                 g, cpu_ready[g], dma_ready[g], mem_we[g]);
      end
      total++;
      if (mem_addr[g] !== 16'h0 || mem_wdata[g] !== 16'h0) begin
        bad++;
        $display("FAIL reset_mem[%0d]: mem_addr=%h mem_wdata=%h want 0000 0000",
                 g, mem_addr[g], mem_wdata[g]);
      end
      total++;
      if (cpu_rdata[g] !== 16'h0 || dma_rdata[g] !== 16'h0) begin
        bad++;
        $display("FAIL reset_rdata[%0d]: cpu_rdata=%h dma_rdata=%h want 0000 0000",
                 g, cpu_rdata[g], dma_rdata[g]);
      end
    end
  endtask

  // Lone CPU read on the W=1 instance: access in n+1..n+2, ready at n+3.
  task automatic test_cpu_read();
    apply_reset();
    cpu_we   = 1'b0;
    cpu_addr = 16'h1234;
    cpu_req  = 1'b1;                              // cycle n
    total++;
    if (mem_addr[0] !== 16'h0) begin
      bad++; $display("FAIL rd_idle_addr: got %h want 0000", mem_addr[0]);
    end
    tick(); cpu_req = 1'b0;                       // n+1
    total++;
    if (mem_addr[0] !== 16'h1234 || mem_we[0] !== 1'b0 || cpu_ready[0] !== 1'b0) begin
      bad++; $display("FAIL rd_acc1: addr=%h we=%b rdy=%b want 1234 0 0",
                      mem_addr[0], mem_we[0], cpu_ready[0]);
    end
    tick();                                       // n+2
    total++;
    if (mem_addr[0] !== 16'h1234 || cpu_ready[0] !== 1'b0) begin
      bad++; $display("FAIL rd_acc2: addr=%h rdy=%b want 1234 0", mem_addr[0], cpu_ready[0]);
    end
    tick();                                       // n+3
    total++;
    if (cpu_ready[0] !== 1'b1 || cpu_rdata[0] !== 16'hBEEF || mem_addr[0] !== 16'h0) begin
      bad++; $display("FAIL rd_ready: rdy=%b rdata=%h addr=%h want 1 beef 0000",
                      cpu_ready[0], cpu_rdata[0], mem_addr[0]);
    end
    tick();                                       // n+4
    total++;
    if (cpu_ready[0] !== 1'b0 || cpu_rdata[0] !== 16'hBEEF || dma_ready[0] !== 1'b0) begin
      bad++; $display("FAIL rd_after: rdy=%b rdata=%h dma_rdy=%b want 0 beef 0",
                      cpu_ready[0], cpu_rdata[0], dma_ready[0]);
    end
    repeat (4) tick();
  endtask

  // W=0 instance: load rdata with a read, then a write must leave it alone.
  task automatic test_cpu_write();
    apply_reset();
    cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;   // read, cycle n
    tick(); cpu_req = 1'b0;                               // n+1 access
    tick();                                               // n+2 ready
    total++;
    if (cpu_ready[1] !== 1'b1 || cpu_rdata[1] !== 16'hBEEF) begin
      bad++; $display("FAIL w0_read: rdy=%b rdata=%h want 1 beef", cpu_ready[1], cpu_rdata[1]);
    end
    repeat (5) tick();
    cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 16'h00AA; cpu_req = 1'b1;  // cycle m
    total++;
    if (mem_we[1] !== 1'b0) begin
      bad++; $display("FAIL wr_pre_we: got %b want 0", mem_we[1]);
    end
    tick(); cpu_req = 1'b0;                               // m+1
    total++;
    if (mem_we[1] !== 1'b1 || mem_addr[1] !== 16'h8000 || mem_wdata[1] !== 16'h00AA) begin
      bad++; $display("FAIL wr_acc: we=%b addr=%h wdata=%h want 1 8000 00aa",
                      mem_we[1], mem_addr[1], mem_wdata[1]);
    end
    tick();                                               // m+2
    total++;
    if (mem_we[1] !== 1'b0 || cpu_ready[1] !== 1'b1 || cpu_rdata[1] !== 16'hBEEF) begin
      bad++; $display("FAIL wr_done: we=%b rdy=%b rdata=%h want 0 1 beef",
                      mem_we[1], cpu_ready[1], cpu_rdata[1]);
    end
    repeat (6) tick();
    cpu_we = 1'b0;
  endtask

  // Collect the first n grant owners on instance 0 (1 = DMA) and compare.
  task automatic run_grants(input string name, input int n, input logic exp_dma [20]);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 100) begin
      tick();
      cyc++;
      total++;
      if ((cpu_ready[0] & dma_ready[0]) !== 1'b0) begin
        bad++; $display("FAIL %s_both_ready: cycle %0d both readies high", name, cyc);
      end
      if (cpu_ready[0] === 1'b1 || dma_ready[0] === 1'b1) begin
        total++;
        if (dma_ready[0] !== exp_dma[got]) begin
          bad++; $display("FAIL %s_grant%0d: dma=%b want %b", name, got, dma_ready[0], exp_dma[got]);
        end
        got++;
      end
    end
    total++;
    if (got !== n) begin
      bad++; $display("FAIL %s_timeout: saw %0d grants want %0d", name, got, n);
    end
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_starve();
    logic exp_dma [20] = '{0,0,0,0,1, 0,0,0,0,1, 0,0,0,0,0, 0,0,0,0,0};
    apply_reset();
    cpu_addr = 16'h1111; dma_addr = 16'h2222;
    cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0;
    run_grants("starve", 10, exp_dma);
  endtask

  // With lock: four CPU wins arm the starvation guard, the forced DMA grant
  // opens an 8-access burst, the CPU then wins, and DMA only returns once the
  // guard fires again (lock continuation needs the previous grant to be DMA).
  task automatic test_burst();
    logic exp_dma [20] = '{0,0,0,0, 1,1,1,1,1,1,1,1, 0,0,0,0, 1, 0,0,0};
    apply_reset();
    cpu_addr = 16'h1111; dma_addr = 16'h2222;
    cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
    run_grants("burst", 17, exp_dma);
  endtask

  // W=3 instance: reset during the first cycle of a DMA write.
  task automatic test_reset_mid_access();
    int pulses = 0;
    apply_reset();
    dma_we = 1'b1; dma_addr = 16'h4444; dma_wdata = 16'h5555; dma_req = 1'b1;  // n
    tick(); dma_req = 1'b0;                                                   // n+1
    total++;
    if (mem_we[2] !== 1'b1 || mem_addr[2] !== 16'h4444) begin
      bad++; $display("FAIL rst_acc: we=%b addr=%h want 1 4444", mem_we[2], mem_addr[2]);
    end
    reset = 1'b1;
    tick(); reset = 1'b0;                                                     // n+2
    total++;
    if (mem_we[2] !== 1'b0 || mem_addr[2] !== 16'h0 || dma_ready[2] !== 1'b0) begin
      bad++; $display("FAIL rst_abort: we=%b addr=%h rdy=%b want 0 0000 0",
                      mem_we[2], mem_addr[2], dma_ready[2]);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dma_ready[2] === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL rst_no_ready: saw %0d pulses want 0", pulses);
    end
    // Fresh DMA read must take exactly W+1 access cycles (wait counter cleared).
    dma_we = 1'b0; dma_addr = 16'h0010; dma_req = 1'b1;                      // k
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) dma_req = 1'b0;
      total++;
      if (dma_ready[2] !== 1'b0 || mem_we[2] !== 1'b0) begin
        bad++; $display("FAIL rst_rd_early%0d: rdy=%b we=%b want 0 0", i, dma_ready[2], mem_we[2]);
      end
    end
    tick();                                                                   // k+5
    total++;
    if (dma_ready[2] !== 1'b1 || dma_rdata[2] !== 16'hC0CE) begin
      bad++; $display("FAIL rst_rd_done: rdy=%b rdata=%h want 1 c0ce", dma_ready[2], dma_rdata[2]);
    end
    repeat (4) tick();
  endtask

  // W=1 instance: CPU reads 0..3 with req held, one access per 3 cycles.
  task automatic test_back_to_back();
    logic [15:0] exp_rd [4] = '{16'hC0DE, 16'hC0DF, 16'hC0DC, 16'hC0DD};
    int k = 0;
    int cyc = 0;
    int prev = 0;
    int extra = 0;
    logic drop = 1'b0;
    apply_reset();
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_req = 1'b1;                     // cycle 0
    while (k < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (drop) begin
        cpu_req = 1'b0;
        drop    = 1'b0;
      end
      if (cpu_ready[0] === 1'b1) begin
        total++;
        if (cpu_rdata[0] !== exp_rd[k]) begin
          bad++; $display("FAIL b2b_rdata%0d: got %h want %h", k, cpu_rdata[0], exp_rd[k]);
        end
        total++;
        if ((cyc - prev) !== 3) begin
          bad++; $display("FAIL b2b_spacing%0d: got %0d cycles want 3", k, cyc - prev);
        end
        prev = cyc;
        k++;
        if (k < 4) cpu_addr = 16'(k);
        if (k == 3) drop = 1'b1;
      end
    end
    total++;
    if (k !== 4) begin
      bad++; $display("FAIL b2b_timeout: saw %0d readies want 4", k);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ready[0] === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL b2b_extra: saw %0d extra readies want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_starve();
    test_burst();
    test_reset_mid_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
